// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared types and constants for the register-file write scheduler
package rf_write_scheduler_pkg;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_APU = 1'b1
    } req_e;

    localparam int X0_ADDR     = 0;
    localparam int COLL_LIMIT  = 7;
    localparam int COLL_CNT_W  = 3;
    localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/rf_write_scheduler_rr_arbiter2.sv
// rtl/rf_write_scheduler_rr_arbiter2.sv - two-input round-robin arbiter with last-grant register
module rf_write_scheduler_rr_arbiter2
    import rf_write_scheduler_pkg::*;
(
    input  logic       clk_int,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    input  logic [1:0] block,
    output logic [1:0] ready,
    output logic [1:0] accept
);

    req_e last_grant;

    // A requester is refused only when the other one is contending and it is the other's turn,
    // so a requester's ready never looks at its own valid.
    always_comb begin
        ready[REQ_LSU] = en && !block[REQ_LSU]
                         && !(valid[REQ_APU] && !block[REQ_APU] && last_grant == REQ_LSU);
        ready[REQ_APU] = en && !block[REQ_APU]
                         && !(valid[REQ_LSU] && !block[REQ_LSU] && last_grant == REQ_APU);
        accept         = valid & ready;
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_APU;
        end else if (accept[REQ_LSU]) begin
            last_grant <= REQ_LSU;
        end else if (accept[REQ_APU]) begin
            last_grant <= REQ_APU;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - schedules EX, LSU and APU writebacks onto two register-file write ports
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk_int,
    input  logic                   rst_n,
    input  logic                   halt_i,
    input  logic                   ex_we_i,
    input  logic [ADDR_WIDTH-1:0]  ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]  ex_wdata_i,
    input  logic                   lsu_valid_i,
    output logic                   lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]  lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]  lsu_wdata_i,
    input  logic                   apu_valid_i,
    output logic                   apu_ready_o,
    input  logic [ADDR_WIDTH-1:0]  apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]  apu_wdata_i,
    output logic                   we_a_o,
    output logic [ADDR_WIDTH-1:0]  waddr_a_o,
    output logic [DATA_WIDTH-1:0]  wdata_a_o,
    output logic                   we_b_o,
    output logic [ADDR_WIDTH-1:0]  waddr_b_o,
    output logic [DATA_WIDTH-1:0]  wdata_b_o,
    output logic [GRANT_CNT_W-1:0] grant_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_ADDR);

    logic                  ex_live, lsu_coll, apu_coll;
    logic                  coll_pending, coll_force, ex_write;
    logic [COLL_CNT_W-1:0] coll_cnt;
    logic [1:0]            valid, block, ready, accept;

    always_comb begin
        ex_live      = ex_we_i && (ex_waddr_i != X0);
        lsu_coll     = ex_live && (lsu_waddr_i == ex_waddr_i);
        apu_coll     = ex_live && (apu_waddr_i == ex_waddr_i);
        // Stalled purely by collision: something collides and nothing else could go instead.
        coll_pending = !halt_i
                       && ((lsu_valid_i && lsu_coll) || (apu_valid_i && apu_coll))
                       && !(lsu_valid_i && !lsu_coll) && !(apu_valid_i && !apu_coll);
        coll_force   = coll_pending && (coll_cnt == COLL_CNT_W'(COLL_LIMIT));
        ex_write     = ex_we_i && !coll_force;
        valid        = '0;
        block        = '0;
        valid[REQ_LSU] = lsu_valid_i;
        valid[REQ_APU] = apu_valid_i;
        block[REQ_LSU] = lsu_coll && !coll_force;
        block[REQ_APU] = apu_coll && !coll_force;
    end

    rf_write_scheduler_rr_arbiter2 u_arb (
        .clk_int (clk_int),
        .rst_n   (rst_n),
        .en      (rst_n && !halt_i),
        .valid   (valid),
        .block   (block),
        .ready   (ready),
        .accept  (accept)
    );

    assign lsu_ready_o = ready[REQ_LSU];
    assign apu_ready_o = ready[REQ_APU];

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt    <= '0;
            we_a_o      <= 1'b0;
            waddr_a_o   <= '0;
            wdata_a_o   <= '0;
            we_b_o      <= 1'b0;
            waddr_b_o   <= '0;
            wdata_b_o   <= '0;
            grant_cnt_o <= '0;
        end else begin
            if (coll_force || !coll_pending) begin
                coll_cnt <= '0;
            end else begin
                coll_cnt <= coll_cnt + COLL_CNT_W'(1);
            end

            we_a_o <= ex_write && (ex_waddr_i != X0);
            if (ex_write && (ex_waddr_i != X0)) begin
                waddr_a_o <= ex_waddr_i;
                wdata_a_o <= ex_wdata_i;
            end

            we_b_o <= 1'b0;
            if (accept[REQ_LSU] && (lsu_waddr_i != X0)) begin
                we_b_o    <= 1'b1;
                waddr_b_o <= lsu_waddr_i;
                wdata_b_o <= lsu_wdata_i;
            end else if (accept[REQ_APU] && (apu_waddr_i != X0)) begin
                we_b_o    <= 1'b1;
                waddr_b_o <= apu_waddr_i;
                wdata_b_o <= apu_wdata_i;
            end

            if ((|accept) && (grant_cnt_o != '1)) begin
                grant_cnt_o <= grant_cnt_o + GRANT_CNT_W'(1);
            end
        end
    end

    // Forced grants mean the in-order pipeline broke its own write ordering.
    a_no_coll_force: assert property (@(posedge clk_int) disable iff (!rst_n) !coll_force);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - directed vector bench for rf_write_scheduler
module tb_rf_write_scheduler;

    logic        clk_int = 1'b0;
    logic        rst_n   = 1'b0;
    logic        halt_i, ex_we_i, lsu_valid_i, apu_valid_i;
    logic [5:0]  ex_waddr_i, lsu_waddr_i, apu_waddr_i;
    logic [31:0] ex_wdata_i, lsu_wdata_i, apu_wdata_i;
    logic        lsu_ready_o, apu_ready_o, we_a_o, we_b_o;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic [15:0] grant_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_int = ~clk_int;

    rf_write_scheduler dut (
        .clk_int     (clk_int),
        .rst_n       (rst_n),
        .halt_i      (halt_i),
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .apu_valid_i (apu_valid_i),
        .apu_ready_o (apu_ready_o),
        .apu_waddr_i (apu_waddr_i),
        .apu_wdata_i (apu_wdata_i),
        .we_a_o      (we_a_o),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_b_o      (we_b_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .grant_cnt_o (grant_cnt_o)
    );

    typedef struct {
        logic        halt, ex_we;
        logic [5:0]  ex_a;
        logic [31:0] ex_d;
        logic        lv;
        logic [5:0]  la;
        logic [31:0] ld;
        logic        av;
        logic [5:0]  aa;
        logic [31:0] ad;
        logic        rl, ra, we_a;
        logic [5:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [5:0]  wa_b;
        logic [31:0] wd_b;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic halt, input logic ex_we, input logic [5:0] ex_a, input logic [31:0] ex_d,
                         input logic lv, input logic [5:0] la, input logic [31:0] ld,
                         input logic av, input logic [5:0] aa, input logic [31:0] ad);
        halt_i = halt; ex_we_i = ex_we; ex_waddr_i = ex_a; ex_wdata_i = ex_d;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
        apu_valid_i = av; apu_waddr_i = aa; apu_wdata_i = ad;
    endtask

    initial begin
        //           halt ex_we ex_a  ex_d          lv la  ld            av aa  ad            rl ra we_a wa_a wd_a          we_b wa_b wd_b          cnt
        vecs[0]  = '{0, 1, 6'd5,  32'hDEAD_BEEF, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         1, 1, 1, 6'd5, 32'hDEAD_BEEF, 0, 6'd0,  32'h0,         16'd0};
        vecs[1]  = '{0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         1, 1, 0, 6'd5, 32'hDEAD_BEEF, 0, 6'd0,  32'h0,         16'd0};
        vecs[2]  = '{0, 0, 6'd0,  32'h0,         1, 6'd3,  32'h1111_1111, 1, 6'd40, 32'h2222_2222, 1, 0, 0, 6'd5, 32'hDEAD_BEEF, 1, 6'd3,  32'h1111_1111, 16'd1};
        vecs[3]  = '{0, 0, 6'd0,  32'h0,         1, 6'd3,  32'h1111_1111, 1, 6'd40, 32'h2222_2222, 0, 1, 0, 6'd5, 32'hDEAD_BEEF, 1, 6'd40, 32'h2222_2222, 16'd2};
        vecs[4]  = '{0, 0, 6'd0,  32'h0,         1, 6'd3,  32'h1111_1111, 1, 6'd40, 32'h2222_2222, 1, 0, 0, 6'd5, 32'hDEAD_BEEF, 1, 6'd3,  32'h1111_1111, 16'd3};
        vecs[5]  = '{0, 0, 6'd0,  32'h0,         1, 6'd3,  32'h1111_1111, 1, 6'd40, 32'h2222_2222, 0, 1, 0, 6'd5, 32'hDEAD_BEEF, 1, 6'd40, 32'h2222_2222, 16'd4};
        vecs[6]  = '{0, 1, 6'd7,  32'h77,        1, 6'd7,  32'hAAAA_0007, 0, 6'd0,  32'h0,         0, 1, 1, 6'd7, 32'h77,        0, 6'd40, 32'h2222_2222, 16'd4};
        vecs[7]  = '{0, 0, 6'd0,  32'h0,         1, 6'd7,  32'hAAAA_0007, 0, 6'd0,  32'h0,         1, 0, 0, 6'd7, 32'h77,        1, 6'd7,  32'hAAAA_0007, 16'd5};
        vecs[8]  = '{0, 0, 6'd0,  32'h0,         1, 6'd0,  32'h1234_5678, 0, 6'd0,  32'h0,         1, 1, 0, 6'd7, 32'h77,        0, 6'd7,  32'hAAAA_0007, 16'd6};
        vecs[9]  = '{0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         1, 6'd32, 32'hF0F0_F0F0, 0, 1, 0, 6'd7, 32'h77,        1, 6'd32, 32'hF0F0_F0F0, 16'd7};
        vecs[10] = '{0, 0, 6'd0,  32'h0,         1, 6'd12, 32'hC,         1, 6'd13, 32'hD,         1, 0, 0, 6'd7, 32'h77,        1, 6'd12, 32'hC,         16'd8};
        vecs[11] = '{1, 1, 6'd9,  32'h99,        1, 6'd12, 32'hC,         1, 6'd13, 32'hD,         0, 0, 1, 6'd9, 32'h99,        0, 6'd12, 32'hC,         16'd8};
        vecs[12] = '{1, 0, 6'd0,  32'h0,         1, 6'd12, 32'hC,         1, 6'd13, 32'hD,         0, 0, 0, 6'd9, 32'h99,        0, 6'd12, 32'hC,         16'd8};
        vecs[13] = '{0, 0, 6'd0,  32'h0,         1, 6'd12, 32'hC,         1, 6'd13, 32'hD,         0, 1, 0, 6'd9, 32'h99,        1, 6'd13, 32'hD,         16'd9};
        vecs[14] = '{0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         1, 1, 0, 6'd9, 32'h99,        0, 6'd13, 32'hD,         16'd9};
        vecs[15] = '{0, 1, 6'd3,  32'h33,        1, 6'd3,  32'h3,         1, 6'd40, 32'h44,        0, 1, 1, 6'd3, 32'h33,        1, 6'd40, 32'h44,        16'd10};
        vecs[16] = '{0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         0, 6'd0,  32'h0,         1, 1, 0, 6'd3, 32'h33,        0, 6'd40, 32'h44,        16'd10};
        vecs[17] = '{0, 1, 6'd0,  32'h55,        1, 6'd0,  32'h66,        0, 6'd0,  32'h0,         1, 0, 0, 6'd3, 32'h33,        0, 6'd40, 32'h44,        16'd11};

        // Reset state, with requesters pushing so readies are shown gated.
        drive(0, 1, 6'd5, 32'h1, 1, 6'd3, 32'h2, 1, 6'd40, 32'h3);
        repeat (2) @(posedge clk_int);
        #1;
        check("rst_lsu_ready", 32'(lsu_ready_o), 32'd0);
        check("rst_apu_ready", 32'(apu_ready_o), 32'd0);
        check("rst_we_a", 32'(we_a_o), 32'd0);
        check("rst_we_b", 32'(we_b_o), 32'd0);
        check("rst_waddr_a", 32'(waddr_a_o), 32'd0);
        check("rst_wdata_b", wdata_b_o, 32'd0);
        check("rst_cnt", 32'(grant_cnt_o), 32'd0);
        @(negedge clk_int);
        drive(0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk_int);
            drive(vecs[i].halt, vecs[i].ex_we, vecs[i].ex_a, vecs[i].ex_d,
                  vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].av, vecs[i].aa, vecs[i].ad);
            #1;
            check($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready_o), 32'(vecs[i].rl));
            check($sformatf("v%0d_apu_ready", i), 32'(apu_ready_o), 32'(vecs[i].ra));
            @(posedge clk_int);
            #1;
            check($sformatf("v%0d_we_a", i), 32'(we_a_o), 32'(vecs[i].we_a));
            check($sformatf("v%0d_waddr_a", i), 32'(waddr_a_o), 32'(vecs[i].wa_a));
            check($sformatf("v%0d_wdata_a", i), wdata_a_o, vecs[i].wd_a);
            check($sformatf("v%0d_we_b", i), 32'(we_b_o), 32'(vecs[i].we_b));
            check($sformatf("v%0d_waddr_b", i), 32'(waddr_b_o), 32'(vecs[i].wa_b));
            check($sformatf("v%0d_wdata_b", i), wdata_b_o, vecs[i].wd_b);
            check($sformatf("v%0d_grant_cnt", i), 32'(grant_cnt_o), 32'(vecs[i].cnt));
        end

        // Reset right after an LSU accept discards the registered write and the count.
        @(negedge clk_int);
        drive(0, 0, 6'd0, 32'h0, 1, 6'd20, 32'hBB, 0, 6'd0, 32'h0);
        @(posedge clk_int);
        #1;
        check("mid_we_b_before_rst", 32'(we_b_o), 32'd1);
        check("mid_cnt_before_rst", 32'(grant_cnt_o), 32'd12);
        #1;
        rst_n = 1'b0;
        drive(0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0);
        #1;
        check("mid_we_b_in_rst", 32'(we_b_o), 32'd0);
        check("mid_cnt_in_rst", 32'(grant_cnt_o), 32'd0);
        repeat (2) @(posedge clk_int);
        @(negedge clk_int);
        rst_n = 1'b1;
        @(posedge clk_int);
        #1;
        check("mid_we_b_after_rst", 32'(we_b_o), 32'd0);
        check("mid_waddr_b_after_rst", 32'(waddr_b_o), 32'd0);
        @(negedge clk_int);
        drive(0, 0, 6'd0, 32'h0, 1, 6'd3, 32'h1111_1111, 1, 6'd40, 32'h2222_2222);
        #1;
        check("post_rst_tie_lsu_ready", 32'(lsu_ready_o), 32'd1);
        check("post_rst_tie_apu_ready", 32'(apu_ready_o), 32'd0);
        @(posedge clk_int);
        #1;
        check("post_rst_tie_waddr_b", 32'(waddr_b_o), 32'd3);
        check("post_rst_tie_cnt", 32'(grant_cnt_o), 32'd1);
        @(negedge clk_int);
        drive(0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0);
        @(posedge clk_int);
        #1;
        check("post_rst_idle_we_b", 32'(we_b_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: cv32e40p_rf_write_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, register address width; bit 5 set selects an FP register.
REQ-002 Parameter DATA_WIDTH, default 32, write data width.
REQ-003 clk_int  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 halt_i  input  1  when high, no new port-B grants are issued.
REQ-006 ex_we_i  input  1  EX-stage writeback request; has no backpressure and is always accepted.
REQ-007 ex_waddr_i  input  ADDR_WIDTH  EX destination register.
REQ-008 ex_wdata_i  input  DATA_WIDTH  EX writeback data.
REQ-009 lsu_valid_i / lsu_ready_o  input / output  1 / 1  LSU writeback handshake.
REQ-010 lsu_waddr_i, lsu_wdata_i  input  ADDR_WIDTH, DATA_WIDTH  LSU destination register and data.
REQ-011 apu_valid_i / apu_ready_o  input / output  1 / 1  APU/FPU writeback handshake.
REQ-012 apu_waddr_i, apu_wdata_i  input  ADDR_WIDTH, DATA_WIDTH  APU destination register and data.
REQ-013 we_a_o, waddr_a_o, wdata_a_o  output  1, ADDR_WIDTH, DATA_WIDTH  register-file write port A.
REQ-014 we_b_o, waddr_b_o, wdata_b_o  output  1, ADDR_WIDTH, DATA_WIDTH  register-file write port B.
REQ-015 grant_cnt_o  output  16  saturating count of accepted port-B transfers.

Function
REQ-016 Port A SHALL carry only EX writes; port B SHALL carry only LSU or APU writes.
REQ-017 All port outputs SHALL be registered, giving a latency of exactly 1 cycle from request or accept to we_x_o high.
REQ-018 A transfer SHALL complete on the cycle where valid && ready are both high; ready SHALL depend only on current inputs and state, never on valid of the same requester.
REQ-019 Port-B arbitration SHALL be round-robin using a 1-bit last-grant register: when both requesters are valid, the one not granted last SHALL win. The register SHALL update only on an accepted transfer.
REQ-020 When exactly one requester is valid and eligible, that requester SHALL be granted regardless of the last-grant register.
REQ-021 A write with waddr==0 (x0) SHALL be accepted and consumed, but we_x_o SHALL stay 0 for that write; waddr 32 (f0) is a real write and SHALL be performed.
REQ-022 Collision: if the port-B candidate's waddr equals ex_waddr_i while ex_we_i is high (x0 excluded), that candidate SHALL NOT be granted this cycle. The other valid requester MAY be granted instead if it does not collide.
REQ-023 Collision stall counter: a 3-bit counter SHALL count consecutive cycles in which any valid port-B requester is blocked only by collision. At 7, the blocked requester SHALL be granted and ex_we_i SHALL be masked from port A, and the counter SHALL clear.
REQ-024 Fault reporting: REQ-023 SHALL never fire in legal in-order operation. Its firing SHALL be reported by an assertion, not by a port.
REQ-025 halt_i high SHALL force lsu_ready_o = apu_ready_o = 0. Already registered port outputs SHALL still drain next cycle, and EX writes SHALL continue.
REQ-026 With no request, we_a_o and we_b_o SHALL be 0 on the next cycle. waddr/wdata SHALL hold their last value.
REQ-027 grant_cnt_o SHALL increment by 1 per accepted LSU or APU transfer (x0 included) and saturate at 16'hFFFF.
REQ-028 A requester dropping valid without a grant SHALL be legal, and arbitration state SHALL be unaffected.

Reset
REQ-029 While rst_n is low, all outputs SHALL be 0: we_a_o=we_b_o=0, addresses/data 0, readies 0, grant_cnt_o=0; last-grant SHALL be set to APU, so LSU wins the first tie.
REQ-030 Reset SHALL clear the collision counter. Reset asserted mid-transfer SHALL discard the registered write; the write SHALL NOT appear after reset.

Structure
REQ-031 A shared package SHALL hold: the requester enum {REQ_LSU, REQ_APU}, the x0 address constant, the collision limit constant (7), and the grant counter width (16).
REQ-032 One sub-module, cv32e40p_rr_arbiter2 (2-input round-robin with last-grant register and grant-enable), SHALL be instantiated. All other logic SHALL be inline.

Verification
REQ-033 EX-only: ex_we_i=1, addr 5, data 32'hDEAD_BEEF -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=32'hDEAD_BEEF; we_b_o=0.
REQ-034 Tie for 4 cycles after reset: LSU (addr 3) and APU (addr 40) both held valid -> grants alternate LSU, APU, LSU, APU, and grant_cnt_o=4.
REQ-035 Collision: EX addr 7 and LSU addr 7 in the same cycle with APU idle -> lsu_ready_o=0; on the following cycle, with EX idle, the LSU is granted and port B writes addr 7.
REQ-036 x0 drop: LSU valid, addr 0 -> lsu_ready_o=1, we_b_o stays 0, grant_cnt_o increments by 1.
REQ-037 Halt: halt_i=1 with both requesters valid -> both readies 0 for the full halt period; EX addr 9 is still written; the write accepted the cycle before halt still appears on port B.
REQ-038 Reset mid-op: rst_n low in the cycle after an LSU accept -> we_b_o=0 after reset and grant_cnt_o=0; the first tie after reset goes to LSU.
